// File: rtl/ser_rcv_ctrl_pkg.sv
// Shared definitions for the serial receive controller: register map,
// CTRL bit layout, access FSM states and reset defaults.
package ser_rcv_ctrl_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_DATA   = 2'd1,
    REG_BITLEN = 2'd2,
    REG_DROP   = 2'd3
  } reg_addr_e;

  localparam int unsigned CTRL_READY = 0;
  localparam int unsigned CTRL_IE    = 1;
  localparam int unsigned CTRL_OVR   = 2;
  localparam int unsigned CTRL_RXEN  = 3;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned WORD_W  = 32;

  localparam logic [15:0] BIT_LEN_RST_DEF = 16'd434;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_ACK  = 1'b1
  } acc_state_e;

  // CTRL read payload as it appears on data_out
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  level;
    logic [3:0]  rsvd_lo;
    logic        rxen;
    logic        ovr;
    logic        ie;
    logic        ready;
  } ctrl_reg_t;

endpackage

// File: rtl/ser_rcv_ctrl_fifo.sv
// Byte FIFO for received data; head is visible combinationally on dout.
// Push on full without pop and pop on empty are silently ignored.
module ser_rcv_ctrl_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/ser_rcv_ctrl.sv
// Bus-side controller for the serial receiver: two-cycle register access,
// bit length config, receive FIFO with overrun tracking and interrupt.
module ser_rcv_ctrl
  import ser_rcv_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter logic [15:0] BIT_LEN_RST = BIT_LEN_RST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        wr,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        wt,
  output logic        irq,
  output logic [15:0] bit_len,
  input  logic        rcv_full,
  input  logic [7:0]  rcv_data
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  acc_state_e  state_q;
  acc_state_e  state_d;
  logic        access_c;
  logic        rd_c;
  logic        wr_c;
  reg_addr_e   reg_sel;

  logic        ie;
  logic        ovr;
  logic        rxen;
  logic [15:0] drop;

  logic          fifo_empty;
  logic          fifo_full;
  logic [7:0]    fifo_head;
  logic [LW-1:0] level;
  logic [LW-1:0] level_d;
  logic          pop_c;
  logic          push_req_c;
  logic          push_c;
  logic          overrun_c;
  logic          ie_d;
  logic [31:0]   rdata_c;
  ctrl_reg_t     ctrl_c;
  logic          unused_data_c;

  assign unused_data_c = ^data_in[31:16];

  // Access FSM: first cycle is the wait cycle and carries the access edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    wt       = 1'b0;
    access_c = 1'b0;
    case (state_q)
      ACC_IDLE: begin
        if (en) begin
          state_d  = ACC_ACK;
          wt       = 1'b1;
          access_c = 1'b1;
        end
      end
      ACC_ACK: state_d = ACC_IDLE;
      default: state_d = ACC_IDLE;
    endcase
  end

  assign reg_sel    = reg_addr_e'(addr);
  assign rd_c       = access_c & ~wr;
  assign wr_c       = access_c & wr;
  assign pop_c      = rd_c & (reg_sel == REG_DATA) & ~fifo_empty;
  assign push_req_c = rcv_full & rxen;
  assign overrun_c  = push_req_c & fifo_full & ~pop_c;
  assign push_c     = push_req_c & ~overrun_c;
  assign level_d    = level + LW'(push_c) - LW'(pop_c);
  assign ie_d       = (wr_c && reg_sel == REG_CTRL) ? data_in[CTRL_IE] : ie;

  ser_rcv_ctrl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .din   (rcv_data),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  always_comb begin
    ctrl_c       = '0;
    ctrl_c.ready = ~fifo_empty;
    ctrl_c.ie    = ie;
    ctrl_c.ovr   = ovr;
    ctrl_c.rxen  = rxen;
    ctrl_c.level = 8'(level);
    rdata_c      = '0;
    case (reg_sel)
      REG_CTRL:   rdata_c = ctrl_c;
      REG_DATA:   rdata_c = fifo_empty ? '0 : WORD_W'(fifo_head);
      REG_BITLEN: rdata_c = WORD_W'(bit_len);
      REG_DROP:   rdata_c = WORD_W'(drop);
      default:    rdata_c = '0;
    endcase
  end

  // Register file; an overrun beats a same-edge OVR/DROP clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie       <= 1'b0;
      ovr      <= 1'b0;
      rxen     <= 1'b1;
      drop     <= '0;
      bit_len  <= BIT_LEN_RST;
      data_out <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_c && reg_sel == REG_CTRL) begin
        ie   <= data_in[CTRL_IE];
        rxen <= data_in[CTRL_RXEN];
      end
      if (overrun_c)
        ovr <= 1'b1;
      else if (wr_c && reg_sel == REG_CTRL && data_in[CTRL_OVR])
        ovr <= 1'b0;
      if (wr_c && reg_sel == REG_BITLEN) bit_len <= data_in[15:0];
      if (overrun_c) begin
        if (wr_c && reg_sel == REG_DROP) drop <= 16'd1;
        else if (drop != 16'hFFFF)       drop <= drop + 16'd1;
      end else if (wr_c && reg_sel == REG_DROP) begin
        drop <= '0;
      end
      if (rd_c) data_out <= rdata_c;
      irq <= ie_d & (level_d != '0);
    end
  end

endmodule

// File: tb/tb_ser_rcv_ctrl.sv
// Bench for ser_rcv_ctrl: register vector table, directed corner sequences
// and random traffic compared against a queue-based reference model.
module tb_ser_rcv_ctrl;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        wr;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        wt;
  logic        irq;
  logic [15:0] bit_len;
  logic        rcv_full;
  logic [7:0]  rcv_data;

  ser_rcv_ctrl #(.DEPTH(DEPTH), .BIT_LEN_RST(16'd434)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .wt       (wt),
    .irq      (irq),
    .bit_len  (bit_len),
    .rcv_full (rcv_full),
    .rcv_data (rcv_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  logic [7:0]  mq[$];
  logic        m_ie;
  logic        m_ovr;
  logic        m_rxen;
  logic [15:0] m_drop;
  logic [15:0] m_bl;
  logic [31:0] m_last;

  typedef struct {
    logic        w;
    logic [1:0]  a;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp_rd;
    logic [15:0] exp_bl;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ie   = 1'b0;
    m_ovr  = 1'b0;
    m_rxen = 1'b1;
    m_drop = 16'd0;
    m_bl   = 16'd434;
    m_last = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      2'd0: v = {16'h0, 8'(mq.size()), 4'h0, m_rxen, m_ovr, m_ie, 1'(mq.size() != 0)};
      2'd1: if (mq.size() != 0) v = {24'h0, mq[0]};
      2'd2: v = {16'h0, m_bl};
      default: v = {16'h0, m_drop};
    endcase
    return v;
  endfunction

  // Byte arrival handled by the model: a pop at this edge frees a slot first
  task automatic model_push(input logic [7:0] pb, input logic rx, output logic ovr_ev);
    ovr_ev = 1'b0;
    if (rx) begin
      if (mq.size() < DEPTH) mq.push_back(pb);
      else ovr_ev = 1'b1;
    end
  endtask

  task automatic check_outputs(input string nm);
    check({nm, "_irq"}, 32'(irq), 32'(m_ie && (mq.size() != 0)));
    check({nm, "_bitlen"}, 32'(bit_len), 32'(m_bl));
  endtask

  task automatic bus_op(input logic w, input logic [1:0] a, input logic [31:0] wd,
                        input logic p, input logic [7:0] pb, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        rx_old;
    logic        ovr_ev;
    @(negedge clk);
    en = 1'b1; wr = w; addr = a; data_in = wd;
    rcv_full = p; rcv_data = pb;
    #1 check("wt_first", 32'(wt), 32'd1);
    @(posedge clk);
    exp_rd = model_read(a);
    rx_old = m_rxen;
    if (!w && a == 2'd1 && mq.size() != 0) void'(mq.pop_front());
    model_push(pb, p & rx_old, ovr_ev);
    if (w && a == 2'd0) begin
      m_ie   = wd[1];
      m_rxen = wd[3];
    end
    if (w && a == 2'd2) m_bl = wd[15:0];
    if (ovr_ev) m_ovr = 1'b1;
    else if (w && a == 2'd0 && wd[2]) m_ovr = 1'b0;
    if (ovr_ev) m_drop = (w && a == 2'd3) ? 16'd1 : ((m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1);
    else if (w && a == 2'd3) m_drop = 16'd0;
    if (!w) m_last = exp_rd;
    @(negedge clk);
    check("wt_second", 32'(wt), 32'd0);
    en = 1'b0; wr = 1'b0; rcv_full = 1'b0;
    check("data_out", data_out, m_last);
    check_outputs("bus");
    rd = data_out;
  endtask

  task automatic rx_byte(input logic [7:0] pb);
    logic ovr_ev;
    @(negedge clk);
    rcv_full = 1'b1; rcv_data = pb;
    @(posedge clk);
    model_push(pb, m_rxen, ovr_ev);
    if (ovr_ev) begin
      m_ovr = 1'b1;
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
    @(negedge clk);
    rcv_full = 1'b0;
    check_outputs("rx");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    n_chk = 0;
    n_err = 0;

    vecs[0] = '{1'b0, 2'd0, 32'h0,  1'b1, 32'h0000_0008, 16'd434};
    vecs[1] = '{1'b1, 2'd2, 32'd27, 1'b0, 32'h0,         16'd27};
    vecs[2] = '{1'b0, 2'd2, 32'h0,  1'b1, 32'd27,        16'd27};
    vecs[3] = '{1'b0, 2'd3, 32'h0,  1'b1, 32'h0,         16'd27};
    vecs[4] = '{1'b0, 2'd1, 32'h0,  1'b1, 32'h0,         16'd27};
    vecs[5] = '{1'b1, 2'd0, 32'hA,  1'b0, 32'h0,         16'd27};
    vecs[6] = '{1'b0, 2'd0, 32'h0,  1'b1, 32'h0000_000A, 16'd27};
    vecs[7] = '{1'b1, 2'd1, 32'hFF, 1'b0, 32'h0,         16'd27};
    vecs[8] = '{1'b0, 2'd0, 32'h0,  1'b1, 32'h0000_000A, 16'd27};

    rst_n = 1'b0; en = 1'b0; wr = 1'b0; addr = 2'd0; data_in = 32'd0;
    rcv_full = 1'b0; rcv_data = 8'd0;
    model_reset();
    #12;
    check("rst_data_out", data_out, 32'd0);
    check("rst_wt", 32'(wt), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_bitlen", 32'(bit_len), 32'd434);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      bus_op(vecs[i].w, vecs[i].a, vecs[i].wd, 1'b0, 8'h0, rd);
      if (vecs[i].chk) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_bl", i), 32'(bit_len), 32'(vecs[i].exp_bl));
    end

    // Two bytes with IE set, then drain past empty
    rx_byte(8'hA5);
    check("irq_after_push", 32'(irq), 32'd1);
    rx_byte(8'h3C);
    bus_op(1'b0, 2'd0, 32'h0, 1'b0, 8'h0, rd); check("ctrl_lvl2", rd, 32'h0000_020B);
    bus_op(1'b0, 2'd1, 32'h0, 1'b0, 8'h0, rd); check("pop_a5", rd, 32'h0000_00A5);
    bus_op(1'b0, 2'd1, 32'h0, 1'b0, 8'h0, rd); check("pop_3c", rd, 32'h0000_003C);
    check("irq_drained", 32'(irq), 32'd0);
    bus_op(1'b0, 2'd1, 32'h0, 1'b0, 8'h0, rd); check("pop_empty", rd, 32'h0);
    bus_op(1'b0, 2'd0, 32'h0, 1'b0, 8'h0, rd); check("ctrl_lvl0", rd, 32'h0000_000A);

    // Overrun: six bytes into four slots
    for (int i = 0; i < 6; i++) rx_byte(8'h11 + 8'(i));
    bus_op(1'b0, 2'd0, 32'h0, 1'b0, 8'h0, rd); check("ctrl_ovr", rd, 32'h0000_040F);
    bus_op(1'b0, 2'd3, 32'h0, 1'b0, 8'h0, rd); check("drop_2", rd, 32'd2);
    bus_op(1'b1, 2'd0, 32'hE, 1'b0, 8'h0, rd);
    bus_op(1'b0, 2'd0, 32'h0, 1'b0, 8'h0, rd); check("ovr_cleared", rd, 32'h0000_040B);
    bus_op(1'b1, 2'd3, 32'h0, 1'b0, 8'h0, rd);
    bus_op(1'b0, 2'd3, 32'h0, 1'b0, 8'h0, rd); check("drop_cleared", rd, 32'd0);

    // Full FIFO: pop and push on the same edge
    bus_op(1'b0, 2'd1, 32'h0, 1'b1, 8'h77, rd); check("full_pp_rd", rd, 32'h11);
    bus_op(1'b0, 2'd0, 32'h0, 1'b0, 8'h0, rd); check("full_pp_ctrl", rd, 32'h0000_040B);
    bus_op(1'b0, 2'd1, 32'h0, 1'b0, 8'h0, rd); check("drain_12", rd, 32'h12);
    bus_op(1'b0, 2'd1, 32'h0, 1'b0, 8'h0, rd); check("drain_13", rd, 32'h13);
    bus_op(1'b0, 2'd1, 32'h0, 1'b0, 8'h0, rd); check("drain_14", rd, 32'h14);
    bus_op(1'b0, 2'd1, 32'h0, 1'b0, 8'h0, rd); check("drain_77", rd, 32'h77);
    // Empty FIFO: read and push on the same edge
    bus_op(1'b0, 2'd1, 32'h0, 1'b1, 8'h55, rd); check("empty_pp_rd", rd, 32'h0);
    bus_op(1'b0, 2'd0, 32'h0, 1'b0, 8'h0, rd); check("empty_pp_ctrl", rd, 32'h0000_010B);
    bus_op(1'b0, 2'd1, 32'h0, 1'b0, 8'h0, rd); check("empty_pp_55", rd, 32'h55);

    // Clears coinciding with an overrun
    for (int i = 0; i < 4; i++) rx_byte(8'h21 + 8'(i));
    bus_op(1'b1, 2'd0, 32'hE, 1'b1, 8'h99, rd);
    bus_op(1'b0, 2'd0, 32'h0, 1'b0, 8'h0, rd); check("ovr_set_wins", rd, 32'h0000_040F);
    bus_op(1'b1, 2'd3, 32'h0, 1'b1, 8'h98, rd);
    bus_op(1'b0, 2'd3, 32'h0, 1'b0, 8'h0, rd); check("drop_set_wins", rd, 32'd1);
    bus_op(1'b1, 2'd0, 32'hE, 1'b0, 8'h0, rd);
    for (int i = 0; i < 4; i++) begin
      bus_op(1'b0, 2'd1, 32'h0, 1'b0, 8'h0, rd);
      check("drain_21", rd, 32'h21 + 32'(i));
    end

    // Receiver disabled: arrivals ignored
    bus_op(1'b1, 2'd0, 32'h2, 1'b0, 8'h0, rd);
    for (int i = 0; i < 6; i++) rx_byte(8'hC0 + 8'(i));
    bus_op(1'b0, 2'd0, 32'h0, 1'b0, 8'h0, rd); check("rxen_off_ctrl", rd, 32'h0000_0002);
    bus_op(1'b0, 2'd3, 32'h0, 1'b0, 8'h0, rd); check("rxen_off_drop", rd, 32'd1);

    // Reset with three bytes pending
    bus_op(1'b1, 2'd0, 32'hA, 1'b0, 8'h0, rd);
    for (int i = 0; i < 3; i++) rx_byte(8'h31 + 8'(i));
    check("irq_pending", 32'(irq), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_bitlen", 32'(bit_len), 32'd434);
    check("mid_rst_data_out", data_out, 32'd0);
    model_reset();
    @(negedge clk);
    rcv_full = 1'b1; rcv_data = 8'hEE;
    @(negedge clk);
    rcv_full = 1'b0;
    rst_n = 1'b1;
    bus_op(1'b0, 2'd0, 32'h0, 1'b0, 8'h0, rd); check("post_rst_ctrl", rd, 32'h0000_0008);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [31:0] wd;
      r  = $urandom_range(0, 9);
      wd = $urandom;
      case (r)
        0, 1, 2, 3: rx_byte(8'($urandom));
        4: bus_op(1'b0, 2'($urandom), 32'h0, 1'($urandom), 8'($urandom), rd);
        5: begin
          wd[3] = ($urandom_range(0, 3) != 0);
          bus_op(1'b1, 2'd0, wd, 1'($urandom), 8'($urandom), rd);
        end
        6: bus_op(1'b1, 2'd2, wd, 1'b0, 8'h0, rd);
        7: bus_op(1'b1, 2'd3, wd, 1'($urandom), 8'($urandom), rd);
        default: bus_op(1'b0, 2'd1, 32'h0, 1'($urandom), 8'($urandom), rd);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
